rs_sched: RTL and testbench
===========================

// Module: rs_sched
// PURPOSE
//  Allocation and issue scheduler for one rs_array instance. Each cycle it picks free RS
//  entries for the dispatch slots (drives alloc_sel), and for each issue port picks the
//  oldest woken-up entry (drives issue_sel / rs_use_en). It also blocks ports that feed
//  non-pipelined FUs while they are busy. Sits between dispatch, rs_array and the FU ports.
// PARAMETERS
//  RS_DEPTH       16                 number of RS entries
//  MC_LAT         4                  occupancy in cycles of a multicycle (non-pipelined) FU, >=2
//  `MACHINE_WIDTH / `ISSUE_WIDTH / `ROB_WIDTH   global defines; AGE_W = `ROB_WIDTH+1
// PORTS
//  clk               in   1                      clock
//  rst_n             in   1                      async reset, active low
//  pipe_flush        in   1                      squash all scheduling this cycle
//  dispatch_valid    in   `MACHINE_WIDTH         slot k holds a valid instruction
//  rs_avail          in   RS_DEPTH               entry free (from rs_array)
//  rs_wake_up        in   `ISSUE_WIDTH x RS_DEPTH   per-entry, per-port ready
//  rs_age            in   AGE_W x RS_DEPTH       ROB tag of entry (MSB = wrap bit)
//  rob_head          in   AGE_W                  current ROB head tag
//  fu_ready          in   `ISSUE_WIDTH           port p's FU accepts an op this cycle
//  port_multicycle   in   `ISSUE_WIDTH           port p feeds a non-pipelined FU (static)
//  alloc_sel         out  `MACHINE_WIDTH x RS_DEPTH  one-hot slot select per entry
//  dispatch_stall    out  1                      dispatch group not accepted
//  issue_sel         out  RS_DEPTH x `ISSUE_WIDTH   one-hot entry select per port
//  rs_use_en         out  RS_DEPTH               entry issued this cycle
//  issue_valid       out  `ISSUE_WIDTH           port p issues this cycle
// BEHAVIOUR
//  - alloc_sel, issue_sel, rs_use_en, issue_valid, dispatch_stall are combinational from
//    inputs and state; only state is busy_cnt[p] (0..MC_LAT-1) and optional perf counters.
//  - Reset: busy_cnt = 0, perf counters = 0; outputs therefore 0 with inputs idle.
//  - Allocation, all-or-nothing: N = popcount(dispatch_valid), F = popcount(rs_avail).
//    F >= N: valid slot k (in slot order) gets the k-th free entry, lowest index first;
//    invalid slots get nothing. F < N: no alloc_sel bit set, dispatch_stall = 1.
//    dispatch_stall = 0 when N = 0. An entry is never selected by two slots.
//  - Age: rel(i) = rs_age[i] - rob_head mod 2^AGE_W; smaller rel = older. Ties -> lower index.
//  - Issue: port p eligible if fu_ready[p] && busy_cnt[p]==0. Ports granted in order
//    0..`ISSUE_WIDTH-1; port p picks oldest entry with rs_wake_up[p][i] not already granted
//    to a lower port. issue_valid[p] = grant made; rs_use_en[i] = OR of issue_sel bits of i.
//  - Busy: on grant on port p with port_multicycle[p], busy_cnt[p] <= MC_LAT-1; else if
//    busy_cnt[p] != 0 it decrements each cycle. Port re-eligible MC_LAT cycles after grant.
//  - pipe_flush: alloc_sel, issue_sel, rs_use_en, issue_valid forced 0, dispatch_stall = 0;
//    busy_cnt cleared next edge (in-flight multicycle op is squashed downstream).
//  - Async reset mid-operation clears busy_cnt immediately; no partial grants survive.
//  - rob_head wrap: relative subtraction handles tags straddling the wrap bit.
// CONFIGURATION
//  RS_SCHED_PERF_EN defined: 32-bit counters perf_stall_cnt (cycles dispatch_stall=1) and
//   perf_issue_cnt (sum of issue_valid bits per cycle) plus output ports perf_stall_cnt,
//   perf_issue_cnt; saturate at 2^32-1, cleared by reset only (not flush).
//  Not defined: counters and ports absent; all other behaviour identical.
// TESTING
//  1 RS_DEPTH=16, all avail, dispatch_valid=2'b11 -> slot0 entry0, slot1 entry1, stall=0.
//  2 rs_avail=16'h0001, dispatch_valid=2'b11 -> no alloc_sel bits, dispatch_stall=1.
//  3 rob_head=6'h3E; entries 2,5 ready on port0 with ages 6'h01,6'h3F -> entry5 issued.
//  4 Entry 3 ready on ports 0 and 1 only, entry 7 ready on port1 only, 3 older -> port0
//    gets 3, port1 gets 7, rs_use_en=16'h0088.
//  5 port_multicycle[0]=1, MC_LAT=4, grant at cycle t with port0 always ready ->
//    issue_valid[0] at t, 0 at t+1..t+3, 1 again at t+4.
//  6 pipe_flush with ready entries and busy_cnt=2 -> no grants that cycle, port free next cycle;
//    with RS_SCHED_PERF_EN, 5 stall cycles -> perf_stall_cnt=5.

Source files
------------

// File: rtl/rs_sched.sv
// rs_sched: allocation and issue scheduler for one rs_array instance.
// Allocates free RS entries to dispatch slots (all-or-nothing), picks the
// oldest woken-up entry per issue port, and blocks ports feeding
// non-pipelined FUs while they are occupied.
// Optional feature macro: RS_SCHED_PERF_EN adds saturating 32-bit stall and
// issue counters with matching output ports.

`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 2
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif

module rs_sched #(
    parameter int RS_DEPTH = 16,
    parameter int MC_LAT   = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     pipe_flush,
    input  logic [`MACHINE_WIDTH-1:0]                dispatch_valid,
    input  logic [RS_DEPTH-1:0]                      rs_avail,
    input  logic [`ISSUE_WIDTH-1:0][RS_DEPTH-1:0]    rs_wake_up,
    input  logic [RS_DEPTH-1:0][`ROB_WIDTH:0]        rs_age,
    input  logic [`ROB_WIDTH:0]                      rob_head,
    input  logic [`ISSUE_WIDTH-1:0]                  fu_ready,
    input  logic [`ISSUE_WIDTH-1:0]                  port_multicycle,
    output logic [`MACHINE_WIDTH-1:0][RS_DEPTH-1:0]  alloc_sel,
    output logic                                     dispatch_stall,
    output logic [`ISSUE_WIDTH-1:0][RS_DEPTH-1:0]    issue_sel,
    output logic [RS_DEPTH-1:0]                      rs_use_en,
    output logic [`ISSUE_WIDTH-1:0]                  issue_valid
`ifdef RS_SCHED_PERF_EN
    ,
    output logic [31:0]                              perf_stall_cnt,
    output logic [31:0]                              perf_issue_cnt
`endif
);

    localparam int MW     = `MACHINE_WIDTH;
    localparam int IW     = `ISSUE_WIDTH;
    localparam int AGE_W  = `ROB_WIDTH + 1;
    localparam int BUSY_W = $clog2(MC_LAT);

    logic [BUSY_W-1:0]   busy_cnt [IW];
    logic [AGE_W-1:0]    rel      [RS_DEPTH];
    logic [RS_DEPTH-1:0] alloc_taken;
    logic [RS_DEPTH-1:0] granted;
    logic [RS_DEPTH-1:0] best_vec;
    logic [AGE_W-1:0]    best_rel;
    logic                best_found;
    logic                slot_found;
    int                  n_req;
    int                  n_free;

    // All-or-nothing allocation: valid slot k takes the k-th free entry, lowest index first
    always_comb begin
        alloc_sel      = '0;
        dispatch_stall = 1'b0;
        alloc_taken    = '0;
        slot_found     = 1'b0;
        n_req          = $countones(dispatch_valid);
        n_free         = $countones(rs_avail);
        if (!pipe_flush) begin
            if (n_req > n_free) begin
                dispatch_stall = 1'b1;
            end else begin
                for (int k = 0; k < MW; k++) begin
                    slot_found = 1'b0;
                    if (dispatch_valid[k]) begin
                        for (int i = 0; i < RS_DEPTH; i++) begin
                            if (!slot_found && rs_avail[i] && !alloc_taken[i]) begin
                                alloc_sel[k][i] = 1'b1;
                                alloc_taken[i]  = 1'b1;
                                slot_found      = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Age relative to ROB head; modular subtraction absorbs the wrap bit
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            rel[i] = rs_age[i] - rob_head;
        end
    end

    // Ports granted in order; each picks the oldest awake entry not taken by a lower port
    always_comb begin
        issue_sel   = '0;
        issue_valid = '0;
        rs_use_en   = '0;
        granted     = '0;
        best_vec    = '0;
        best_rel    = '0;
        best_found  = 1'b0;
        for (int p = 0; p < IW; p++) begin
            best_vec   = '0;
            best_rel   = '0;
            best_found = 1'b0;
            if (!pipe_flush && fu_ready[p] && (busy_cnt[p] == '0)) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    // strict compare keeps the lower index on equal age
                    if (rs_wake_up[p][i] && !granted[i] && (!best_found || (rel[i] < best_rel))) begin
                        best_vec   = '0;
                        best_vec[i] = 1'b1;
                        best_rel   = rel[i];
                        best_found = 1'b1;
                    end
                end
            end
            issue_sel[p]   = best_vec;
            issue_valid[p] = best_found;
            granted        = granted | best_vec;
        end
        rs_use_en = granted;
    end

    // Occupancy of non-pipelined FUs; a flush squashes the in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < IW; p++) busy_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < IW; p++) begin
                if (pipe_flush)
                    busy_cnt[p] <= '0;
                else if (issue_valid[p] && port_multicycle[p])
                    busy_cnt[p] <= BUSY_W'(MC_LAT - 1);
                else if (busy_cnt[p] != '0)
                    busy_cnt[p] <= busy_cnt[p] - 1'b1;
            end
        end
    end

`ifdef RS_SCHED_PERF_EN
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Saturating performance counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_issue_cnt <= '0;
        end else begin
            perf_stall_cnt <= sat_add32(perf_stall_cnt, {31'b0, dispatch_stall});
            perf_issue_cnt <= sat_add32(perf_issue_cnt, 32'($countones(issue_valid)));
        end
    end
`endif

endmodule

// File: tb/tb_rs_sched.sv
// Scoreboard bench for rs_sched: stimulus pushes hand-computed expectations,
// a monitor compares them against the DUT outputs every falling edge.

`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 2
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 5
`endif

module tb_rs_sched;
    localparam int D     = 16;
    localparam int MW    = `MACHINE_WIDTH;
    localparam int IW    = `ISSUE_WIDTH;
    localparam int AGE_W = `ROB_WIDTH + 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     pipe_flush;
    logic [MW-1:0]            dispatch_valid;
    logic [D-1:0]             rs_avail;
    logic [IW-1:0][D-1:0]     rs_wake_up;
    logic [D-1:0][AGE_W-1:0]  rs_age;
    logic [AGE_W-1:0]         rob_head;
    logic [IW-1:0]            fu_ready;
    logic [IW-1:0]            port_multicycle;
    logic [MW-1:0][D-1:0]     alloc_sel;
    logic                     dispatch_stall;
    logic [IW-1:0][D-1:0]     issue_sel;
    logic [D-1:0]             rs_use_en;
    logic [IW-1:0]            issue_valid;
`ifdef RS_SCHED_PERF_EN
    logic [31:0]              perf_stall_cnt;
    logic [31:0]              perf_issue_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string                name;
        logic [MW-1:0][D-1:0] alloc;
        logic                 stall;
        logic [IW-1:0][D-1:0] isel;
        logic [D-1:0]         use_en;
        logic [IW-1:0]        ivld;
    } exp_t;

    exp_t exp_q[$];

    rs_sched #(.RS_DEPTH(D), .MC_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
        .dispatch_valid(dispatch_valid), .rs_avail(rs_avail),
        .rs_wake_up(rs_wake_up), .rs_age(rs_age), .rob_head(rob_head),
        .fu_ready(fu_ready), .port_multicycle(port_multicycle),
        .alloc_sel(alloc_sel), .dispatch_stall(dispatch_stall),
        .issue_sel(issue_sel), .rs_use_en(rs_use_en), .issue_valid(issue_valid)
`ifdef RS_SCHED_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_issue_cnt(perf_issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic push(input string nm, input logic [D-1:0] a0, input logic [D-1:0] a1,
                        input logic st, input logic [D-1:0] i0, input logic [D-1:0] i1,
                        input logic [D-1:0] ue, input logic [IW-1:0] iv);
        exp_t e;
        e.name   = nm;
        e.alloc  = '0;
        e.alloc[0] = a0;
        e.alloc[1] = a1;
        e.stall  = st;
        e.isel   = '0;
        e.isel[0] = i0;
        e.isel[1] = i1;
        e.use_en = ue;
        e.ivld   = iv;
        exp_q.push_back(e);
    endtask

    task automatic set_idle();
        pipe_flush      = 1'b0;
        dispatch_valid  = '0;
        rs_avail        = '0;
        rs_wake_up      = '0;
        rs_age          = '0;
        rob_head        = '0;
        fu_ready        = '0;
        port_multicycle = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so each pushed expectation is due at the next falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (alloc_sel !== e.alloc) begin
                    errors++;
                    $display("FAIL %s alloc_sel actual=%h required=%h", e.name, alloc_sel, e.alloc);
                end
                checks++;
                if (dispatch_stall !== e.stall) begin
                    errors++;
                    $display("FAIL %s dispatch_stall actual=%b required=%b", e.name, dispatch_stall, e.stall);
                end
                checks++;
                if (issue_sel !== e.isel) begin
                    errors++;
                    $display("FAIL %s issue_sel actual=%h required=%h", e.name, issue_sel, e.isel);
                end
                checks++;
                if (rs_use_en !== e.use_en) begin
                    errors++;
                    $display("FAIL %s rs_use_en actual=%h required=%h", e.name, rs_use_en, e.use_en);
                end
                checks++;
                if (issue_valid !== e.ivld) begin
                    errors++;
                    $display("FAIL %s issue_valid actual=%b required=%b", e.name, issue_valid, e.ivld);
                end
            end
        end
    end

    initial begin
        int guard;
        set_idle();
        rst_n = 1'b0;

        // reset state, in and out of reset
        next_cycle();
        push("reset_hold", 0, 0, 0, 0, 0, 0, 2'b00);
        next_cycle();
        rst_n = 1'b1;
        push("reset_rel", 0, 0, 0, 0, 0, 0, 2'b00);

        // allocation
        next_cycle();
        rs_avail = 16'hFFFF; dispatch_valid = 2'b11;
        push("alloc_all", 16'h0001, 16'h0002, 0, 0, 0, 0, 2'b00);
        next_cycle();
        rs_avail = 16'hF0F0; dispatch_valid = 2'b10;
        push("alloc_slot1", 16'h0000, 16'h0010, 0, 0, 0, 0, 2'b00);
        next_cycle();
        rs_avail = 16'h8001; dispatch_valid = 2'b11;
        push("alloc_ends", 16'h0001, 16'h8000, 0, 0, 0, 0, 2'b00);
        next_cycle();
        rs_avail = 16'h0001; dispatch_valid = 2'b11;
        push("alloc_short", 0, 0, 1, 0, 0, 0, 2'b00);
        next_cycle();
        rs_avail = 16'h0000; dispatch_valid = 2'b00;
        push("alloc_none", 0, 0, 0, 0, 0, 0, 2'b00);

        // age across wrap: head 3E, entry2 age 01 (rel 3), entry5 age 3F (rel 1)
        next_cycle();
        fu_ready = 2'b11; rob_head = 6'h3E;
        rs_age[2] = 6'h01; rs_age[5] = 6'h3F;
        rs_wake_up[0] = 16'h0024;
        push("age_wrap", 0, 0, 0, 16'h0020, 0, 16'h0020, 2'b01);

        // equal ages on port1: lower index wins
        next_cycle();
        rs_age = '0; rob_head = 6'h00;
        rs_age[4] = 6'h05; rs_age[9] = 6'h05;
        rs_wake_up[0] = '0; rs_wake_up[1] = 16'h0210;
        push("age_tie", 0, 0, 0, 0, 16'h0010, 16'h0010, 2'b10);

        // two ports, shared entry, plus concurrent allocation
        next_cycle();
        rs_age = '0; rs_age[3] = 6'h02; rs_age[7] = 6'h05;
        rs_wake_up[0] = 16'h0008; rs_wake_up[1] = 16'h0088;
        rs_avail = 16'h0300; dispatch_valid = 2'b01;
        push("two_port", 16'h0100, 0, 0, 16'h0008, 16'h0080, 16'h0088, 2'b11);
        next_cycle();
        fu_ready = 2'b10; rs_avail = '0; dispatch_valid = '0;
        push("port0_notready", 0, 0, 0, 0, 16'h0008, 16'h0008, 2'b10);

        // multicycle port0 occupancy
        next_cycle();
        fu_ready = 2'b11; port_multicycle = 2'b01;
        rs_age = '0; rs_wake_up[0] = 16'h0001; rs_wake_up[1] = '0;
        push("mc_t0", 0, 0, 0, 16'h0001, 0, 16'h0001, 2'b01);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            push($sformatf("mc_busy%0d", c), 0, 0, 0, 0, 0, 0, 2'b00);
        end
        next_cycle();
        push("mc_t4", 0, 0, 0, 16'h0001, 0, 16'h0001, 2'b01);
        next_cycle();
        push("mc_t5", 0, 0, 0, 0, 0, 0, 2'b00);

        // flush with busy_cnt=2, ready entries and a would-be stall
        next_cycle();
        pipe_flush = 1'b1; rs_avail = 16'h0001; dispatch_valid = 2'b11;
        push("flush", 0, 0, 0, 0, 0, 0, 2'b00);
        next_cycle();
        pipe_flush = 1'b0; rs_avail = '0; dispatch_valid = '0;
        push("post_flush", 0, 0, 0, 16'h0001, 0, 16'h0001, 2'b01);

        // async reset mid-cycle while port0 busy: port frees within the same cycle
        next_cycle();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        push("async_rst", 0, 0, 0, 16'h0001, 0, 16'h0001, 2'b01);

        // five stall cycles
        next_cycle();
        port_multicycle = '0; rs_wake_up = '0;
        rs_avail = 16'h0001; dispatch_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            push($sformatf("stall%0d", c), 0, 0, 1, 0, 0, 0, 2'b00);
        end
        next_cycle();
        rs_avail = '0; dispatch_valid = '0;
        push("idle_end", 0, 0, 0, 0, 0, 0, 2'b00);
`ifdef RS_SCHED_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd5) begin
            errors++;
            $display("FAIL perf_stall actual=%0d required=5", perf_stall_cnt);
        end
        checks++;
        if (perf_issue_cnt !== 32'd1) begin
            errors++;
            $display("FAIL perf_issue actual=%0d required=1", perf_issue_cnt);
        end
`endif

        // drain the scoreboard with a bounded wait
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
